// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter and registered broadcast stage for the Tomasulo core.
// Define CDB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed highest-index priority.
module cdb_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 4
) (
  input  logic                      clk,
  input  logic                      nRST,
  input  logic [NUM_CH-1:0]         requires,
  input  logic [NUM_CH*LABEL_W-1:0] labelIn,
  input  logic [NUM_CH*DATA_W-1:0]  dataIn,
  output logic [NUM_CH-1:0]         accepts,
  output logic                      BCEN,
  output logic [LABEL_W-1:0]        BClabel,
  output logic [DATA_W-1:0]         BCdata,
  output logic [NUM_CH-1:0]         BCsrc,
  output logic [7:0]                dropCnt
);

  logic [NUM_CH-1:0]  grant;
  logic               anyGrant;
  logic [LABEL_W-1:0] selLabel;
  logic [DATA_W-1:0]  selData;

  logic               bcen_q, bcen_d;
  logic [LABEL_W-1:0] bclabel_q, bclabel_d;
  logic [DATA_W-1:0]  bcdata_q, bcdata_d;
  logic [NUM_CH-1:0]  bcsrc_q, bcsrc_d;
  logic [7:0]         dropcnt_q, dropcnt_d;

`ifdef CDB_ROUND_ROBIN_EN
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [2*NUM_CH-1:0] reqDouble, grantDouble;
  logic [NUM_CH-1:0]   reqRot, pickRot;

  // Rotate so ptr sits at bit 0, take the lowest request, rotate the pick back.
  always_comb begin
    reqDouble = {requires, requires} >> ptr_q;
    reqRot    = reqDouble[NUM_CH-1:0];
    pickRot   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (reqRot[i]) begin
        pickRot    = '0;
        pickRot[i] = 1'b1;
      end
    end
    grantDouble = {{NUM_CH{1'b0}}, pickRot} << ptr_q;
    grant       = grantDouble[NUM_CH-1:0] | grantDouble[2*NUM_CH-1:NUM_CH];
    ptr_d       = ptr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        ptr_d = (i == NUM_CH - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (requires[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end
`endif

  assign accepts  = nRST ? grant : '0;
  assign anyGrant = |grant;

  always_comb begin
    selLabel = '0;
    selData  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        selLabel = selLabel | labelIn[i*LABEL_W +: LABEL_W];
        selData  = selData  | dataIn[i*DATA_W +: DATA_W];
      end
    end
  end

  // A label-0 grant is consumed but never broadcast; it only bumps the drop counter.
  always_comb begin
    bcen_d    = anyGrant && (selLabel != '0);
    bclabel_d = bclabel_q;
    bcdata_d  = bcdata_q;
    bcsrc_d   = bcsrc_q;
    dropcnt_d = dropcnt_q;
    if (anyGrant) begin
      bclabel_d = selLabel;
      bcdata_d  = selData;
      bcsrc_d   = grant;
      if ((selLabel == '0) && (dropcnt_q != 8'hFF)) begin
        dropcnt_d = dropcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      bcen_q    <= 1'b0;
      bclabel_q <= '0;
      bcdata_q  <= '0;
      bcsrc_q   <= '0;
      dropcnt_q <= '0;
    end else begin
      bcen_q    <= bcen_d;
      bclabel_q <= bclabel_d;
      bcdata_q  <= bcdata_d;
      bcsrc_q   <= bcsrc_d;
      dropcnt_q <= dropcnt_d;
    end
  end

  assign BCEN    = bcen_q;
  assign BClabel = bclabel_q;
  assign BCdata  = bcdata_q;
  assign BCsrc   = bcsrc_q;
  assign dropCnt = dropcnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with four channels.
// Contention expectations follow CDB_ROUND_ROBIN_EN when it is defined.
module tb_cdb_arbiter;

  logic         clk;
  logic         nRST;
  logic [3:0]   requires;
  logic [15:0]  labelIn;
  logic [127:0] dataIn;
  logic [3:0]   accepts;
  logic         BCEN;
  logic [3:0]   BClabel;
  logic [31:0]  BCdata;
  logic [3:0]   BCsrc;
  logic [7:0]   dropCnt;

  int testCount = 0;
  int failCount = 0;

  cdb_arbiter #(.NUM_CH(4), .DATA_W(32), .LABEL_W(4)) dut (
    .clk(clk), .nRST(nRST), .requires(requires), .labelIn(labelIn), .dataIn(dataIn),
    .accepts(accepts), .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata), .BCsrc(BCsrc),
    .dropCnt(dropCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic [3:0] lbl, input logic [31:0] dat);
    labelIn[ch*4 +: 4]  = lbl;
    dataIn[ch*32 +: 32] = dat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int expCh;
    nRST     = 1'b0;
    requires = 4'b0000;
    labelIn  = '0;
    dataIn   = '0;

    // Reset state, with requests pending to show accepts is gated
    #2;
    requires = 4'b1111;
    #1;
    checkOutput("rst_accepts", 32'(accepts), 32'h0);
    checkOutput("rst_bcen", 32'(BCEN), 32'h0);
    checkOutput("rst_label", 32'(BClabel), 32'h0);
    checkOutput("rst_data", BCdata, 32'h0);
    checkOutput("rst_src", 32'(BCsrc), 32'h0);
    checkOutput("rst_drop", 32'(dropCnt), 32'h0);
    tick();
    checkOutput("rst_bcen_edge", 32'(BCEN), 32'h0);
    requires = 4'b0000;
    nRST     = 1'b1;

    // Single request on ch0
    applyStimulus(0, 4'h3, 32'h0000_00AA);
    requires = 4'b0001;
    #1;
    checkOutput("single_accepts", 32'(accepts), 32'h1);
    tick();
    requires = 4'b0000;
    #1;
    checkOutput("single_bcen", 32'(BCEN), 32'h1);
    checkOutput("single_label", 32'(BClabel), 32'h3);
    checkOutput("single_data", BCdata, 32'hAA);
    checkOutput("single_src", 32'(BCsrc), 32'h1);
    tick();
    checkOutput("single_bcen_off", 32'(BCEN), 32'h0);

    // Contention
    for (int c = 0; c < 4; c++) applyStimulus(c, 4'(c + 5), 32'h100 + 32'(c));
`ifdef CDB_ROUND_ROBIN_EN
    // ptr is 1 after the ch0 grant, so ch2 wins first, then they alternate
    requires = 4'b0101;
    #1;
    for (int k = 0; k < 6; k++) begin
      expCh = (k % 2 == 0) ? 2 : 0;
      checkOutput("rr_accepts", 32'(accepts), 32'(1 << expCh));
      tick();
      applyStimulus(expCh, 4'(expCh + 5), 32'h200 + 32'(k));
      #1;
      checkOutput("rr_bcen", 32'(BCEN), 32'h1);
      checkOutput("rr_label", 32'(BClabel), 32'(expCh + 5));
      checkOutput("rr_data", BCdata, (k < 2) ? 32'h100 + 32'(expCh) : 32'h200 + 32'(k - 2));
      checkOutput("rr_src", 32'(BCsrc), 32'(1 << expCh));
    end
    requires = 4'b0000;
    #1;
`else
    requires = 4'b1111;
    #1;
    for (int k = 0; k < 4; k++) begin
      expCh = 3 - k;
      checkOutput("fp_accepts", 32'(accepts), 32'(1 << expCh));
      tick();
      requires[expCh] = 1'b0;
      #1;
      checkOutput("fp_bcen", 32'(BCEN), 32'h1);
      checkOutput("fp_label", 32'(BClabel), 32'(expCh + 5));
      checkOutput("fp_data", BCdata, 32'h100 + 32'(expCh));
      checkOutput("fp_src", 32'(BCsrc), 32'(1 << expCh));
    end
`endif
    checkOutput("cont_accepts_idle", 32'(accepts), 32'h0);
    tick();
    checkOutput("cont_bcen_off", 32'(BCEN), 32'h0);

    // Label 0: consumed, not broadcast, counted and saturating
    applyStimulus(1, 4'h0, 32'h0000_DEAD);
    requires = 4'b0010;
    #1;
    checkOutput("lbl0_accepts", 32'(accepts), 32'h2);
    tick();
    checkOutput("lbl0_bcen", 32'(BCEN), 32'h0);
    checkOutput("lbl0_drop1", 32'(dropCnt), 32'h1);
    for (int n = 2; n <= 300; n++) begin
      tick();
      if (n == 254) checkOutput("lbl0_drop254", 32'(dropCnt), 32'd254);
    end
    checkOutput("lbl0_drop_sat", 32'(dropCnt), 32'd255);
    checkOutput("lbl0_bcen_sat", 32'(BCEN), 32'h0);
    requires = 4'b0000;
    #1;

    // Normal broadcast, then idle: BCdata must hold
    applyStimulus(3, 4'h9, 32'h0000_1234);
    requires = 4'b1000;
    #1;
    tick();
    requires = 4'b0000;
    #1;
    checkOutput("pre_idle_bcen", 32'(BCEN), 32'h1);
    checkOutput("pre_idle_data", BCdata, 32'h1234);
    for (int n = 0; n < 10; n++) begin
      tick();
      checkOutput("idle_accepts", 32'(accepts), 32'h0);
      checkOutput("idle_bcen", 32'(BCEN), 32'h0);
      checkOutput("idle_data", BCdata, 32'h1234);
    end

    // Async reset while a broadcast is on the bus
    applyStimulus(2, 4'h7, 32'h0000_0055);
    requires = 4'b0100;
    #1;
    tick();
    checkOutput("ar_bcen_before", 32'(BCEN), 32'h1);
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("ar_bcen", 32'(BCEN), 32'h0);
    checkOutput("ar_label", 32'(BClabel), 32'h0);
    checkOutput("ar_data", BCdata, 32'h0);
    checkOutput("ar_src", 32'(BCsrc), 32'h0);
    checkOutput("ar_accepts", 32'(accepts), 32'h0);
    checkOutput("ar_drop", 32'(dropCnt), 32'h0);
    #2;
    nRST = 1'b1;
    #1;
    checkOutput("ar_post_accepts", 32'(accepts), 32'h4);
    tick();
    requires = 4'b0000;
    #1;
    checkOutput("ar_post_bcen", 32'(BCEN), 32'h1);
    checkOutput("ar_post_label", 32'(BClabel), 32'h7);
    checkOutput("ar_post_data", BCdata, 32'h55);
    checkOutput("ar_post_src", 32'(BCsrc), 32'h4);
    tick();
    checkOutput("ar_post_bcen_off", 32'(BCEN), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Parametrised common-data-bus arbiter and broadcast register for the Tomasulo core. It generalises the fixed 4-way require/accept helper to NUM_CH functional-unit channels (alu, mul, div, ls, ...). Each cycle it grants at most one requesting channel and latches that channel's label/result onto the registered broadcast bus (BCEN/BClabel/BCdata). The broadcast bus feeds the register file, the reservation stations and the load/store queue.

Parameters:
NUM_CH, 4, number of requesting functional-unit channels (2..16)
DATA_W, 32, result data width
LABEL_W, 4, reservation-station tag width; label value 0 is reserved as "no tag"

Ports:
clk  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
requires  input  NUM_CH  per-channel broadcast request; bit i = channel i
labelIn  input  NUM_CH*LABEL_W  packed per-channel tags; channel i at [i*LABEL_W +: LABEL_W]
dataIn  input  NUM_CH*DATA_W  packed per-channel results; channel i at [i*DATA_W +: DATA_W]
accepts  output  NUM_CH  one-hot grant, combinational, same cycle as request
BCEN  output  1  broadcast valid, registered
BClabel  output  LABEL_W  broadcast tag, registered
BCdata  output  DATA_W  broadcast result, registered
BCsrc  output  NUM_CH  one-hot source channel of current broadcast, registered
dropCnt  output  8  saturating count of accepted label-0 requests

Behaviour:
- Reset (nRST low, asynchronous): BCEN=0, BClabel=0, BCdata=0, BCsrc=0, dropCnt=0, priority pointer=0. accepts is forced to 0 while nRST is low.
- Grant: accepts is the one-hot selection among the set bits of requires, or 0 if no bit is set. At most one bit of accepts is ever set.
- Base arbitration: fixed priority. The highest index wins (channel NUM_CH-1, normally ls, beats div, which beats mul, which beats alu).
- Handshake: a channel holds require, label and data stable until it sees accepts[i]=1 at a clock edge. That edge completes the transfer. In the next cycle the channel may deassert require or present a new result. A channel with require high and no accept keeps waiting, with no timeout.
- Latency: a result granted in cycle T appears on BCEN/BClabel/BCdata/BCsrc in cycle T+1 for exactly one cycle. Back-to-back grants give a continuous broadcast of one result per cycle.
- No grant in cycle T: BCEN=0 in T+1. BClabel, BCdata and BCsrc hold their previous values (do-not-care when BCEN=0).
- Label-0 request: it is granted and consumed normally, but BCEN stays 0 in T+1 and dropCnt increments, saturating at 255. This is an error indicator for the verifier.
- Simultaneous requests: the losers keep their request asserted and are re-arbitrated every cycle.
- requires changing to 0 without an accept: legal. That channel is simply not granted.
- Reset mid-broadcast: BCEN clears immediately. Any grant issued in the cycle of reset assertion is lost. The requesting unit must re-request after reset, which it does naturally because its own reset clears its state.

Optional Feature:
CDB_ROUND_ROBIN_EN
- Defined: round-robin arbitration. A pointer ptr (log2 NUM_CH bits, reset 0) marks the highest-priority channel. Priority descends ptr, ptr+1, ..., wrapping modulo NUM_CH. After any grant to channel g, ptr becomes (g+1) mod NUM_CH. ptr is unchanged when there is no grant.
- Not defined: fixed highest-index priority as above, and no pointer register exists.
- Latency, handshake and label-0 handling are identical in both builds.

Test Plan:
- Single request: requires=4'b0001, labelIn ch0=4'h3, dataIn ch0=32'h0000_00AA, one cycle → accepts=4'b0001 in that cycle; next cycle BCEN=1, BClabel=3, BCdata=0xAA, BCsrc=4'b0001; the cycle after, BCEN=0.
- Contention (fixed priority): requires=4'b1111 held, each channel dropping its request after its accept → grant order ch3, ch2, ch1, ch0 on consecutive cycles; BCEN=1 for 4 consecutive cycles with matching labels.
- Contention (CDB_ROUND_ROBIN_EN): ch0 and ch2 request continuously with new data each cycle → grants alternate 0, 2, 0, 2; neither channel waits more than 1 cycle.
- Label 0: ch1 requests with label 0, data 0xDEAD → accepts[1]=1; next cycle BCEN=0 and dropCnt goes 0→1. Repeat 300 times → dropCnt=255.
- Async reset: assert nRST low mid-cycle while BCEN=1 → BCEN, BClabel, BCdata, BCsrc and accepts are 0 before the next clock edge; after nRST releases, the first request is broadcast with the normal 1-cycle latency.
- Idle: requires=0 for 10 cycles → accepts=0 and BCEN=0 throughout; BCdata holds its last value.
